// File: rtl/mem_bus_if.sv
// mem_bus_if: core-side request/response and external bus signals of the memory bridge
interface mem_bus_if;
    logic        req;
    logic        is_fetch;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        stall;
    logic        access_err;
    logic [1:0]  err_cause;
    logic        bus_valid;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_we;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    modport slave (
        input  req, is_fetch, adr, wdata, mem_write, funct3, bus_ready, bus_rdata,
        output rdata, stall, access_err, err_cause, bus_valid, bus_addr, bus_wdata, bus_be, bus_we
    );
    modport master (
        output req, is_fetch, adr, wdata, mem_write, funct3, bus_ready, bus_rdata,
        input  rdata, stall, access_err, err_cause, bus_valid, bus_addr, bus_wdata, bus_be, bus_we
    );
endinterface

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: turns single-cycle core memory requests into handshaked bus accesses
module mem_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input logic      clk,
    input logic      rst_n,
    mem_bus_if.slave mb
);
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           f3_q, f3_d;
    logic [1:0]           lo_q, lo_d;
    logic [31:0]          rdata_q, rdata_d, bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    logic [3:0]           bus_be_q, bus_be_d;
    logic                 bus_valid_q, bus_valid_d, bus_we_q, bus_we_d, access_err_q, access_err_d;
    logic [1:0]           err_cause_q, err_cause_d;
    logic [2:0]           f3;
    logic                 illegal, misaligned, timeout;
    logic [1:0]           cause;
    logic [31:0]          shifted, ext;
    // request decode: fetches behave as lw; illegal funct3 outranks misalignment
    always_comb begin
        f3         = mb.is_fetch ? 3'b010 : mb.funct3;
        illegal    = !mb.is_fetch && ((mb.funct3[1:0] == 2'b11) || (mb.funct3[2] && (mb.mem_write || mb.funct3[1])));
        misaligned = (f3[1:0] == 2'b01 && mb.adr[0]) || (f3[1:0] == 2'b10 && mb.adr[1:0] != 2'b00);
        cause      = illegal ? 2'b10 : misaligned ? 2'b01 : 2'b00;
    end
    // lane select and extension of the returned word; timeout when this idle cycle is the last allowed
    always_comb begin
        shifted = mb.bus_rdata >> {lo_q, 3'b000};
        ext     = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]} :
                  f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]} : mb.bus_rdata;
        timeout = !mb.bus_ready && cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    end
    // next-state and next-output computation for the IDLE/BUS/DONE sequence
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        f3_d         = f3_q;
        lo_d         = lo_q;
        rdata_d      = rdata_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_be_d     = bus_be_q;
        bus_valid_d  = bus_valid_q;
        bus_we_d     = bus_we_q;
        access_err_d = 1'b0;
        err_cause_d  = 2'b00;
        case (state_q)
            IDLE: if (mb.req) begin
                f3_d         = f3;
                lo_d         = mb.adr[1:0];
                cnt_d        = '0;
                bus_addr_d   = {mb.adr[31:2], 2'b00};
                bus_we_d     = mb.mem_write && cause == 2'b00;
                bus_be_d     = !mb.mem_write ? 4'b1111 :
                               f3[1:0] == 2'b00 ? 4'b0001 << mb.adr[1:0] :
                               f3[1:0] == 2'b01 ? (mb.adr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
                bus_wdata_d  = f3[1:0] == 2'b00 ? {4{mb.wdata[7:0]}} :
                               f3[1:0] == 2'b01 ? {2{mb.wdata[15:0]}} : mb.wdata;
                bus_valid_d  = cause == 2'b00;
                state_d      = cause == 2'b00 ? BUS : DONE;
                access_err_d = cause != 2'b00;
                err_cause_d  = cause;
                rdata_d      = cause != 2'b00 ? '0 : rdata_q;
            end
            BUS: begin
                cnt_d = mb.bus_ready ? cnt_q : cnt_q + 1'b1;
                if (mb.bus_ready || timeout) begin
                    state_d      = DONE;
                    bus_valid_d  = 1'b0;
                    bus_we_d     = 1'b0;
                    access_err_d = !mb.bus_ready;
                    err_cause_d  = mb.bus_ready ? 2'b00 : 2'b11;
                    rdata_d      = !mb.bus_ready ? '0 : bus_we_q ? rdata_q : ext;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // state and registered outputs, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            f3_q         <= '0;
            lo_q         <= '0;
            rdata_q      <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_be_q     <= '0;
            bus_valid_q  <= 1'b0;
            bus_we_q     <= 1'b0;
            access_err_q <= 1'b0;
            err_cause_q  <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            f3_q         <= f3_d;
            lo_q         <= lo_d;
            rdata_q      <= rdata_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_be_q     <= bus_be_d;
            bus_valid_q  <= bus_valid_d;
            bus_we_q     <= bus_we_d;
            access_err_q <= access_err_d;
            err_cause_q  <= err_cause_d;
        end
    end
    assign mb.rdata      = rdata_q;
    assign mb.bus_addr   = bus_addr_q;
    assign mb.bus_wdata  = bus_wdata_q;
    assign mb.bus_be     = bus_be_q;
    assign mb.bus_valid  = bus_valid_q;
    assign mb.bus_we     = bus_we_q;
    assign mb.access_err = access_err_q;
    assign mb.err_cause  = err_cause_q;
    assign mb.stall      = rst_n && (state_q == IDLE ? mb.req : state_q == BUS);
endmodule

// File: doc/mem_bus_bridge.md
Name: mem_bus_bridge

Overview:
- Sits directly downstream of the multi-cycle control unit and datapath. It turns each single-cycle memory access request (instruction fetch, load or store) into a handshaked access on the external memory/peripheral bus.
- Drives byte lanes for sb/sh/sw, and sign- or zero-extends load data for lb/lh/lw/lbu/lhu.
- Holds `stall` high so the main FSM freezes while a bus access is outstanding.
- Detects misaligned accesses, illegal funct3 values and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: number of cycles in BUS with `bus_ready` low before the access is aborted with an error.
- CNT_WIDTH, 8: width of the timeout counter. Must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  1  core requests a memory access; held high until the cycle `stall` is low
- is_fetch  input  1  access is an instruction fetch; forces word read, funct3 ignored
- adr  input  32  byte address (output of the core's adr_src mux)
- wdata  input  32  store data (rs2), right-aligned
- mem_write  input  1  1 = store, 0 = load/fetch
- funct3  input  3  load/store width and signedness (RV32I encoding)
- rdata  output  32  extended load data / fetched word; valid in DONE
- stall  output  1  core must hold its state this cycle
- access_err  output  1  one-cycle pulse in DONE when the access failed
- err_cause  output  2  00 none, 01 misaligned, 10 illegal funct3, 11 timeout; valid with access_err
- bus_valid  output  1  bus request
- bus_addr  output  32  word-aligned address ({adr[31:2],2'b00})
- bus_wdata  output  32  lane-replicated store data
- bus_be  output  4  byte enables
- bus_we  output  1  bus write
- bus_ready  input  1  bus completes the transfer this cycle
- bus_rdata  input  32  read word, valid when bus_ready is high

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-access): state=IDLE. `bus_valid`, `bus_we`, `access_err` = 0. `bus_addr`, `bus_wdata`, `rdata` = 0. `bus_be` = 0. `err_cause` = 00. Counter = 0.
- States: IDLE, BUS, DONE.
- IDLE:
  - `stall` = `req` (combinational).
  - On `req`, latch adr, wdata, mem_write, funct3 and is_fetch, and decode them.
  - If the access is illegal or misaligned, go to DONE with the error flagged and no bus cycle issued.
  - Otherwise go to BUS.
- Width decode (non-fetch):
  - Stores: funct3 000=sb, 001=sh, 010=sw.
  - Loads: funct3 000=lb, 001=lh, 010=lw, 100=lbu, 101=lhu.
  - Any other funct3 value is illegal (cause 10).
- Alignment: misaligned (cause 01) when:
  - halfword access and adr[0]=1;
  - word access or fetch and adr[1:0]≠00.
  - Illegal funct3 takes priority over misaligned.
- Lanes (stores):
  - sb: `bus_be` = 0001 << adr[1:0]; `bus_wdata` = the low byte replicated ×4.
  - sh: `bus_be` = adr[1] ? 1100 : 0011; `bus_wdata` = the low half replicated ×2.
  - sw: `bus_be` = 1111.
  - Reads and fetches: `bus_be` = 1111.
- BUS:
  - `bus_valid` = 1; `bus_addr`, `bus_wdata`, `bus_be`, `bus_we` are registered and stable throughout.
  - `stall` = 1.
  - Counter increments each cycle that `bus_ready` is low.
  - On `bus_ready`: capture `bus_rdata`, select the byte/half by adr[1:0], extend per funct3 into `rdata` (stores leave `rdata` unchanged), then go to DONE.
  - If the counter reaches TIMEOUT_CYCLES with `bus_ready` still low: drop `bus_valid`, set cause 11, `rdata` = 0, go to DONE.
  - `bus_ready` arriving in the same cycle the timeout is reached counts as success.
- DONE:
  - `stall` = 0.
  - `rdata` holds its value.
  - `access_err` pulses high only if an error was flagged.
  - Go to IDLE unconditionally; `req` is ignored in this cycle because it belongs to the access that just completed.
  - For an error, `rdata` = 0 and the bus is never written.
- Latency: a zero-wait-state bus completes an access in 3 cycles (IDLE→BUS→DONE). Each wait state adds one cycle. An error detected in IDLE completes in 2 cycles.
- `bus_ready` seen outside BUS is ignored.
- `req` dropping while in BUS does not abort the access.

Test Plan:
- lw, adr=0x100, `bus_rdata`=0x8765_4321, `bus_ready` on the first BUS cycle → `stall` high for 2 cycles; `rdata`=0x8765_4321 in DONE; `bus_be`=1111, `bus_we`=0.
- lb at 0x103, `bus_rdata`=0x80xx_xxxx → `rdata`=0xFFFF_FF80. lbu at the same address → 0x0000_0080. lhu at 0x102 with `bus_rdata`=0xBEEF_0000 → 0x0000_BEEF.
- sb, adr=0x201, wdata=0x0000_00AB → `bus_be`=0010, `bus_wdata`=0xABAB_ABAB, `bus_addr`=0x200, `bus_we`=1. sh at 0x202 → `bus_be`=1100.
- Misaligned lw at 0x101 → `bus_valid` never asserted; `access_err`=1, `err_cause`=01, `rdata`=0 on cycle 2. funct3=011 → `err_cause`=10.
- `bus_ready` held low with TIMEOUT_CYCLES=4 → `bus_valid` high 4 cycles then drops; DONE with `err_cause`=11. `bus_ready` arriving on cycle 4 → success, no error.
- 3 wait states, then `rst_n` low mid-BUS → `bus_valid`=0 and `stall`=0 immediately; after release a new fetch at 0x0 completes normally.
